// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers that recovers to the committed state on flush.
// Define FREE_LIST_STATS_EN to add the stall_cycles and min_free statistics outputs.
module free_list #(
    parameter int SS = 2,
    parameter int NUM_PREGS = 64,
    localparam int DEPTH = NUM_PREGS - 32,
    localparam int PREG_W = $clog2(NUM_PREGS),
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SS-1:0]                alloc_req,
    output logic                         alloc_ok,
    output logic [SS-1:0][PREG_W-1:0]    alloc_preg,
    input  logic [SS-1:0]                free_we,
    input  logic [SS-1:0][PREG_W-1:0]    free_preg,
    input  logic                         flush,
    output logic [CNT_W-1:0]             free_count
`ifdef FREE_LIST_STATS_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [CNT_W-1:0]             min_free
`endif
);
    logic [PREG_W-1:0] entries_q [DEPTH];
    logic [PREG_W-1:0] entries_d [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W-1:0]  alloc_cnt, free_cnt, rd_idx, wr_idx;

    always_comb begin
        alloc_cnt = '0;
        rd_idx = '0;
        alloc_preg = '0;
        for (int i = 0; i < SS; i++) begin
            rd_idx = rd_q + alloc_cnt;
            alloc_preg[i] = entries_q[rd_idx[IDX_W-1:0]];
            alloc_cnt = alloc_cnt + PTR_W'(alloc_req[i]);
        end
        free_count = CNT_W'(wr_q - rd_q);
        alloc_ok = free_count >= CNT_W'(alloc_cnt);
        entries_d = entries_q;
        free_cnt = '0;
        wr_idx = '0;
        // p0 is hardwired zero and must never re-enter the list
        for (int i = 0; i < SS; i++) begin
            wr_idx = wr_q + free_cnt;
            if (free_we[i] && free_preg[i] != '0) begin
                entries_d[wr_idx[IDX_W-1:0]] = free_preg[i];
                free_cnt = free_cnt + PTR_W'(1);
            end
        end
        wr_d = wr_q + free_cnt;
        rd_d = flush ? wr_d - PTR_W'(DEPTH) : alloc_ok ? rd_q + alloc_cnt : rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
            wr_q <= PTR_W'(DEPTH);
            for (int k = 0; k < DEPTH; k++) entries_q[k] <= PREG_W'(32 + k);
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            entries_q <= entries_d;
        end
    end

`ifdef FREE_LIST_STATS_EN
    logic [31:0]      stall_q, stall_d;
    logic [CNT_W-1:0] min_q, min_d;

    always_comb begin
        stall_d = (|alloc_req && !alloc_ok && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        min_d = (free_count < min_q) ? free_count : min_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            min_q <= CNT_W'(DEPTH);
        end else begin
            stall_q <= stall_d;
            min_q <= min_d;
        end
    end

    assign stall_cycles = stall_q;
    assign min_free = min_q;
`endif
endmodule
